mpsoc_ahb3_master: RTL

MPSOC_AHB3_MASTER -- requirements
Module: mpsoc_ahb3_master

---
 rtl/mpsoc_pkg.sv | 32 +++
 rtl/mpsoc_ahb3_addr_gen.sv | 16 +
 rtl/mpsoc_ahb3_master.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mpsoc_pkg.sv
// rtl/mpsoc_pkg.sv - shared AHB3-Lite encodings and small helpers
// Contents: HTRANS/HBURST/HSIZE/HRESP encodings, fixed HPROT value,
//           addr_aligned() check of a start address against an HSIZE.
package mpsoc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HWORD   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Data access, privileged, non-bufferable, non-cacheable.
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Largest HSIZE is 1024 bits = 128 bytes, so 7 low address bits suffice.
  function automatic logic addr_aligned(input logic [6:0] addr_lsb, input logic [2:0] size);
    logic [6:0] mask;
    mask = 7'((8'd1 << size) - 8'd1);
    return (addr_lsb & mask) == 7'd0;
  endfunction

endpackage

// File: rtl/mpsoc_ahb3_addr_gen.sv
// rtl/mpsoc_ahb3_addr_gen.sv - next beat address and 1 KB boundary detect
// Ports: addr (current beat address), size (HSIZE) ->
//        next_addr (addr + 2**size), new_kb (next_addr starts a 1 KB page).
module mpsoc_ahb3_addr_gen #(
  parameter int HADDR_SIZE = 64
) (
  input  logic [HADDR_SIZE-1:0] addr,
  input  logic [2:0]            size,
  output logic [HADDR_SIZE-1:0] next_addr,
  output logic                  new_kb
);

  assign next_addr = addr + (HADDR_SIZE'(1) << size);
  assign new_kb    = (next_addr[9:0] == 10'd0);

endmodule

// File: rtl/mpsoc_ahb3_master.sv
// rtl/mpsoc_ahb3_master.sv - AHB3-Lite master: SINGLE/INCR bursts of up to 16 beats
// Ports: HCLK, HRESETn (async, active-low);
//        request side: req_i, we_i, addr_i, size_i, len_i, wdata_i / wrdy_o,
//        rdata_o, rvalid_o, busy_o, done_o, err_o;
//        AHB side: HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
//        HMASTLOCK out; HRDATA, HREADY, HRESP in.
module mpsoc_ahb3_master
  import mpsoc_pkg::*;
#(
  parameter int HADDR_SIZE = 64,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [HADDR_SIZE-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [3:0]            len_i,
  input  logic [HDATA_SIZE-1:0] wdata_i,
  output logic                  wrdy_o,
  output logic [HDATA_SIZE-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(HDATA_SIZE / 8));

  state_t                state_q, state_d;
  logic [3:0]            beats_q;   // address phases still to issue after the current one
  logic                  dphase_q;  // in ADDR: a previous beat's data phase is outstanding
  logic [HADDR_SIZE-1:0] next_addr;
  logic                  new_kb;
  logic                  req_ok, pending, accept, data_ok, err_first;

  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;
  assign busy_o    = (state_q != ST_IDLE);

  assign req_ok    = (size_i <= MAX_SIZE) && addr_aligned(addr_i[6:0], size_i);
  assign pending   = ((state_q == ST_ADDR) && dphase_q) || (state_q == ST_DATA);
  assign accept    = (state_q == ST_ADDR) && HREADY;
  assign data_ok   = pending && HREADY && (HRESP == HRESP_OKAY);
  // First cycle of the two-cycle error response: the beat on the address
  // bus is still unaccepted, so it can be cancelled by dropping HTRANS.
  assign err_first = pending && !HREADY && (HRESP == HRESP_ERROR);
  assign wrdy_o    = accept && HWRITE;

  mpsoc_ahb3_addr_gen #(.HADDR_SIZE(HADDR_SIZE)) u_addr_gen (
    .addr      (HADDR),
    .size      (HSIZE),
    .next_addr (next_addr),
    .new_kb    (new_kb)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_i && req_ok) state_d = ST_ADDR;
      ST_ADDR: begin
        if (err_first)                     state_d = ST_ERR;
        else if (accept && beats_q == 4'd0) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (err_first)   state_d = ST_ERR;
        else if (HREADY) state_d = ST_IDLE;
      end
      ST_ERR:  if (HREADY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR    <= '0;
      HWDATA   <= '0;
      HWRITE   <= 1'b0;
      HSIZE    <= HSIZE_BYTE;
      HBURST   <= HBURST_SINGLE;
      HTRANS   <= HTRANS_IDLE;
      beats_q  <= 4'd0;
      dphase_q <= 1'b0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      rvalid_o <= data_ok && !HWRITE;
      if (data_ok && !HWRITE) rdata_o <= HRDATA;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            if (req_ok) begin
              HADDR    <= addr_i;
              HWRITE   <= we_i;
              HSIZE    <= size_i;
              HBURST   <= (len_i == 4'd0) ? HBURST_SINGLE : HBURST_INCR;
              HTRANS   <= HTRANS_NONSEQ;
              beats_q  <= len_i;
              dphase_q <= 1'b0;
            end else begin
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (err_first) begin
            HTRANS <= HTRANS_IDLE;
          end else if (HREADY) begin
            dphase_q <= 1'b1;
            if (HWRITE) HWDATA <= wdata_i;
            if (beats_q == 4'd0) begin
              HTRANS <= HTRANS_IDLE;
            end else begin
              HADDR   <= next_addr;
              HTRANS  <= new_kb ? HTRANS_NONSEQ : HTRANS_SEQ;
              beats_q <= beats_q - 4'd1;
            end
          end
        end
        ST_DATA: if (!err_first && HREADY) done_o <= 1'b1;
        ST_ERR: begin
          if (HREADY) begin
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
